io_read_port_source: RTL and testbench
======================================

// Module: io_read_port_source
//
// PURPOSE
// Producer end of one Octavo I/O read port (io_read_data / io_read_EF / io_rden).
// It buffers words from an external valid/ready source in a show-ahead FIFO and
// presents them to the core. The core's read port is the consumer.
// One instance serves one free read port of the A or B memory.
//
// PARAMETERS
// WORD_WIDTH     36   width of one data word, matching the core datapath
// DEPTH          8    FIFO entries; a power of two, minimum 2
// ADDR_WIDTH     3    log2(DEPTH)
// RAMSTYLE       "MLAB, no_rw_check"   synthesis attribute for the storage array
//
// PORTS
// clock          in   1            single clock for all logic
// reset_n        in   1            asynchronous, active-low reset
// in_data        in   WORD_WIDTH   word from the external producer
// in_valid       in   1            in_data is valid this cycle
// in_ready       out  1            FIFO accepts a word this cycle
// io_read_data   out  WORD_WIDTH   head-of-FIFO word presented to the core
// io_read_EF     out  1            1 = a word is available (not empty)
// io_rden        in   1            core consumes the head word this cycle
// count          out  ADDR_WIDTH+1 occupancy, 0..DEPTH
// underflow      out  1            sticky: io_rden was seen while io_read_EF=0
//
// BEHAVIOUR
// - Reset (async assert, sync deassert at the instantiating level) forces:
//   count=0, read/write pointers=0, io_read_EF=0, io_read_data=0, in_ready=0,
//   underflow=0.
// - in_ready comes from a register: in_ready = (count < DEPTH).
//   It has no combinational path from io_rden.
// - Push occurs when in_valid & in_ready. Pop occurs when io_rden & io_read_EF.
// - Latency: a word pushed at cycle N appears on io_read_data with
//   io_read_EF=1 at cycle N+1 (empty FIFO case).
// - After a pop, the next word is on io_read_data in the following cycle.
//   Back-to-back io_rden on consecutive cycles (different threads) drains one
//   word per cycle.
// - io_read_data and io_read_EF are registered.
//   io_read_data holds the last head value while empty. It is never X after reset.
// - Simultaneous push and pop: count is unchanged and both pointers advance.
//   When count==1 this is a pass-through: the new word is the head next cycle
//   and io_read_EF stays 1.
// - Full (count==DEPTH): in_ready=0, so no push can occur.
//   A pop in that cycle raises in_ready in the next cycle, not the same cycle.
// - Empty: io_rden with io_read_EF=0 is ignored. Pointers and count do not
//   change, and underflow is set. It clears only on reset.
// - Pointers wrap modulo DEPTH. count uses ADDR_WIDTH+1 bits, so full and empty
//   are never ambiguous.
// - Reset mid-operation discards all contents, and no partial word is emitted.
// - State machine for the output stage:
//   * EMPTY --push--> VALID
//   * VALID --pop & count==1 & !push--> EMPTY
//   * VALID --otherwise--> VALID
//
// STRUCTURE
// - Shared include (io_port_defs.vh) holds:
//   * IO_EF_EMPTY = 1'b0 and IO_EF_READY = 1'b1
//   * the default FIFO depth/width constants, shared with a matching
//     io_write_port_sink block
// - One sub-module: io_port_fifo_mem.
//   * simple dual-port RAM: DEPTH x WORD_WIDTH, one write port and one read port
//   * registered read, RAMSTYLE attribute
//   * no reset on the array
// - Pointers, count, the output register, in_ready and the output-stage state
//   live in this module. Target is about 150-250 lines total.
//
// TESTING
// 1. Reset with in_valid=1:
//    -> all outputs 0 during reset; in_ready=1 on the first cycle after release.
// 2. Push 0x123456789 into an empty FIFO at cycle N:
//    -> io_read_EF=1 and io_read_data=0x123456789 at N+1, count=1;
//       then io_rden at N+1 -> io_read_EF=0 at N+2.
// 3. Push 8 words (1..8) with no reads:
//    -> count=8 and in_ready=0; a 9th in_valid is not accepted.
//    Pop once -> in_ready=1 in the next cycle; reads return 1..8 in order.
// 4. Continuous push and pop of words 1..20 every cycle with count held at 1:
//    -> io_read_EF never drops; data returns in order 1..20 with no loss
//       across pointer wrap.
// 5. io_rden pulse while empty:
//    -> underflow=1 and stays 1; count stays 0.
//    A following push of 0xA is still delivered as 0xA.
// 6. Assert reset_n=0 with count=5 mid-stream:
//    -> count=0 and io_read_EF=0 immediately (asynchronous).
//    After release, the first word pushed is the first word read.

Source files
------------

// File: rtl/io_read_port_source_pkg.sv
`default_nettype none
// ============================================================================
// Package  : io_read_port_source_pkg
// Purpose  : Shared constants and output-stage state type for the Octavo I/O
//            read-port source and its matching write-port sink.
// Revision : 1.0 - initial release
// ============================================================================
package io_read_port_source_pkg;

    localparam int c_DEFAULT_WORD_WIDTH = 36;
    localparam int c_DEFAULT_DEPTH      = 8;
    localparam int c_DEFAULT_ADDR_WIDTH = 3;
    localparam     c_DEFAULT_RAMSTYLE   = "MLAB, no_rw_check";

    // io_read_EF encoding seen by the core
    localparam logic c_IO_EF_EMPTY = 1'b0;
    localparam logic c_IO_EF_READY = 1'b1;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_VALID = 1'b1
    } out_state_e;

endpackage : io_read_port_source_pkg
`default_nettype wire

// File: rtl/io_port_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : io_port_fifo_mem
// Purpose  : Simple dual-port storage for the I/O port FIFO; one write port,
//            one registered read port, no reset on the array.
// Revision : 1.0 - initial release
// ============================================================================
module io_port_fifo_mem #(
    parameter int WORD_WIDTH = 36,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter     RAMSTYLE   = "MLAB, no_rw_check"
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WORD_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [WORD_WIDTH-1:0] o_rd_data
);

    (* ramstyle = RAMSTYLE *) logic [WORD_WIDTH-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule : io_port_fifo_mem
`default_nettype wire

// File: rtl/io_read_port_source.sv
`default_nettype none
// ============================================================================
// Module   : io_read_port_source
// Purpose  : Producer end of one Octavo I/O read port: show-ahead FIFO from a
//            valid/ready source onto io_read_data / io_read_EF / io_rden.
// Revision : 1.0 - initial release
// ============================================================================
module io_read_port_source
    import io_read_port_source_pkg::*;
#(
    parameter int WORD_WIDTH = c_DEFAULT_WORD_WIDTH,
    parameter int DEPTH      = c_DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = c_DEFAULT_ADDR_WIDTH,
    parameter     RAMSTYLE   = c_DEFAULT_RAMSTYLE
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WORD_WIDTH-1:0] io_read_data,
    output logic                  io_read_EF,
    input  logic                  io_rden,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_TWO    = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH:0]   c_COUNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   c_COUNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic                  r_in_ready;
    logic                  r_underflow;
    out_state_e            r_state;
    logic [WORD_WIDTH-1:0] r_head;
    logic                  r_fwd_hit;
    logic [WORD_WIDTH-1:0] r_fwd_data;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [WORD_WIDTH-1:0] w_mem_q;
    logic [WORD_WIDTH-1:0] w_next_word;

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = io_rden && (r_state == ST_VALID);

    // The RAM is always prefetching the word behind next cycle's head, so a
    // pop can reload the head register without waiting on the read latency.
    assign w_rd_addr   = w_pop ? (r_rd_ptr + c_PTR_TWO) : (r_rd_ptr + c_PTR_ONE);
    assign w_next_word = r_fwd_hit ? r_fwd_data : w_mem_q;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_COUNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_COUNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_underflow <= 1'b0;
            r_fwd_hit   <= 1'b0;
            r_fwd_data  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + c_PTR_ONE;
                r_fwd_data <= in_data;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next < c_COUNT_FULL);
            // A prefetch of the address being written this cycle returns stale
            // data, so that word is taken from the forwarding register instead.
            r_fwd_hit  <= w_push && (r_wr_ptr == w_rd_addr);
            if (io_rden && (r_state == ST_EMPTY)) begin
                r_underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_state <= ST_VALID;
                        r_head  <= in_data;
                    end
                end
                ST_VALID: begin
                    if (w_pop) begin
                        if (r_count == c_COUNT_ONE) begin
                            if (w_push) begin
                                r_head <= in_data;
                            end else begin
                                r_state <= ST_EMPTY;
                            end
                        end else begin
                            r_head <= w_next_word;
                        end
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    io_port_fifo_mem #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAMSTYLE   (RAMSTYLE)
    ) u_mem (
        .clk       (clock),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (in_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_mem_q)
    );

    assign in_ready     = r_in_ready;
    assign io_read_data = r_head;
    assign io_read_EF   = (r_state == ST_VALID) ? c_IO_EF_READY : c_IO_EF_EMPTY;
    assign count        = r_count;
    assign underflow    = r_underflow;

endmodule : io_read_port_source
`default_nettype wire

// File: tb/tb_io_read_port_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_read_port_source
// Purpose  : Self-checking bench for io_read_port_source against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_read_port_source;

    localparam int WW    = 36;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [WW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WW-1:0] io_read_data;
    logic          io_read_EF;
    logic          io_rden = 1'b0;
    logic [AW:0]   count;
    logic          underflow;

    int errors = 0;
    int checks = 0;

    logic [WW-1:0] m_q[$];
    logic [WW-1:0] m_hold;
    bit            m_underflow;
    bit            m_in_ready;

    always #5 clock = ~clock;

    io_read_port_source #(
        .WORD_WIDTH (WW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .RAMSTYLE   ("MLAB, no_rw_check")
    ) u_dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .io_read_data (io_read_data),
        .io_read_EF   (io_read_EF),
        .io_rden      (io_rden),
        .count        (count),
        .underflow    (underflow)
    );

    function automatic logic [WW-1:0] exp_data();
        return (m_q.size() > 0) ? m_q[0] : m_hold;
    endfunction

    function automatic logic exp_ef();
        return (m_q.size() > 0);
    endfunction

    function automatic logic [AW:0] exp_count();
        return (AW+1)'(m_q.size());
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_hold      = '0;
        m_underflow = 1'b0;
        m_in_ready  = 1'b0;
    endtask

    // One clock of stimulus, called and returning at a falling edge.
    task automatic drive(input bit valid, input logic [WW-1:0] data, input bit rden);
        bit push;
        bit pop;
        in_valid = valid;
        in_data  = data;
        io_rden  = rden;
        push = valid && m_in_ready;
        pop  = rden && (m_q.size() > 0);
        if (rden && (m_q.size() == 0)) m_underflow = 1'b1;
        @(posedge clock);
        if (pop) m_hold = m_q.pop_front();
        if (push) m_q.push_back(data);
        m_in_ready = (m_q.size() < DEPTH);
        @(negedge clock);
        in_valid = 1'b0;
        io_rden  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_data  = 36'hFFF;
        repeat (3) @(negedge clock);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (io_read_EF !== 1'b0) begin errors++; $display("FAIL reset_ef: got %b want 0", io_read_EF); end
        checks++; if (io_read_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", io_read_data); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b want 0", underflow); end
        model_reset();
        reset_n = 1'b1;
        drive(1'b1, 36'h55, 1'b0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        checks++; if (count !== exp_count()) begin errors++; $display("FAIL release_count: got %0d want %0d", count, exp_count()); end
        checks++; if (io_read_EF !== exp_ef()) begin errors++; $display("FAIL release_ef: got %b want %b", io_read_EF, exp_ef()); end
    endtask

    task automatic test_single_word();
        drive(1'b1, 36'h123456789, 1'b0);
        checks++; if (io_read_EF !== 1'b1) begin errors++; $display("FAIL single_ef: got %b want 1", io_read_EF); end
        checks++; if (io_read_data !== 36'h123456789) begin errors++; $display("FAIL single_data: got %h want 123456789", io_read_data); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d want 1", count); end
        drive(1'b0, '0, 1'b1);
        checks++; if (io_read_EF !== 1'b0) begin errors++; $display("FAIL single_pop_ef: got %b want 0", io_read_EF); end
        checks++; if (io_read_data !== 36'h123456789) begin errors++; $display("FAIL single_hold: got %h want 123456789", io_read_data); end
    endtask

    task automatic test_full();
        for (int i = 1; i <= DEPTH; i++) drive(1'b1, WW'(i), 1'b0);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        drive(1'b1, 36'h9, 1'b0);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_reject: got %0d want 8", count); end
        // pop while full: push in the same cycle must still be refused
        drive(1'b1, 36'hAA, 1'b1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b want 1", in_ready); end
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_pop_count: got %0d want 7", count); end
        for (int i = 2; i <= DEPTH; i++) begin
            checks++; if (io_read_data !== WW'(i)) begin errors++; $display("FAIL full_order: got %h want %h", io_read_data, WW'(i)); end
            drive(1'b0, '0, 1'b1);
        end
        checks++; if (io_read_EF !== 1'b0) begin errors++; $display("FAIL full_drain_ef: got %b want 0", io_read_EF); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, WW'(1), 1'b0);
        for (int k = 1; k <= 20; k++) begin
            checks++; if (io_read_EF !== 1'b1) begin errors++; $display("FAIL b2b_ef[%0d]: got %b want 1", k, io_read_EF); end
            checks++; if (io_read_data !== WW'(k)) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", k, io_read_data, WW'(k)); end
            checks++; if (count !== 4'd1) begin errors++; $display("FAIL b2b_count[%0d]: got %0d want 1", k, count); end
            drive(k < 20, WW'(k + 1), 1'b1);
        end
        checks++; if (io_read_EF !== 1'b0) begin errors++; $display("FAIL b2b_end_ef: got %b want 0", io_read_EF); end
    endtask

    task automatic test_underflow();
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_before: got %b want 0", underflow); end
        drive(1'b0, '0, 1'b1);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b want 1", underflow); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL uf_count: got %0d want 0", count); end
        drive(1'b0, '0, 1'b0);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b want 1", underflow); end
        drive(1'b1, 36'hA, 1'b0);
        checks++; if (io_read_data !== 36'hA) begin errors++; $display("FAIL uf_next_data: got %h want a", io_read_data); end
        checks++; if (io_read_EF !== 1'b1) begin errors++; $display("FAIL uf_next_ef: got %b want 1", io_read_EF); end
        drive(1'b0, '0, 1'b1);
    endtask

    task automatic test_random();
        int push_pct;
        for (int phase = 0; phase < 3; phase++) begin
            push_pct = (phase == 0) ? 80 : (phase == 1) ? 50 : 25;
            for (int n = 0; n < 150; n++) begin
                drive($urandom_range(0, 99) < push_pct, WW'({$urandom(), $urandom()}),
                      $urandom_range(0, 99) < 50);
                checks++; if (io_read_data !== exp_data()) begin errors++; $display("FAIL rnd_data: got %h want %h", io_read_data, exp_data()); end
                checks++; if (io_read_EF !== exp_ef()) begin errors++; $display("FAIL rnd_ef: got %b want %b", io_read_EF, exp_ef()); end
                checks++; if (count !== exp_count()) begin errors++; $display("FAIL rnd_count: got %0d want %0d", count, exp_count()); end
                checks++; if (in_ready !== m_in_ready) begin errors++; $display("FAIL rnd_in_ready: got %b want %b", in_ready, m_in_ready); end
                checks++; if (underflow !== m_underflow) begin errors++; $display("FAIL rnd_underflow: got %b want %b", underflow, m_underflow); end
            end
        end
    endtask

    task automatic test_async_reset();
        repeat (DEPTH) drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, WW'(36'h300 + i), 1'b0);
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL ar_pre_count: got %0d want 5", count); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL ar_count: got %0d want 0", count); end
        checks++; if (io_read_EF !== 1'b0) begin errors++; $display("FAIL ar_ef: got %b want 0", io_read_EF); end
        checks++; if (io_read_data !== '0) begin errors++; $display("FAIL ar_data: got %h want 0", io_read_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ar_in_ready: got %b want 0", in_ready); end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        drive(1'b0, '0, 1'b0);
        drive(1'b1, 36'h77, 1'b0);
        drive(1'b1, 36'h88, 1'b0);
        checks++; if (io_read_data !== 36'h77) begin errors++; $display("FAIL ar_first: got %h want 77", io_read_data); end
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL ar_count2: got %0d want 2", count); end
        drive(1'b0, '0, 1'b1);
        checks++; if (io_read_data !== 36'h88) begin errors++; $display("FAIL ar_second: got %h want 88", io_read_data); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_word();
        test_full();
        test_back_to_back();
        test_underflow();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_io_read_port_source
`default_nettype wire
